// File: rtl/cfg_shadow_bank.sv
// Bank of NUM_REGS software-visible shadow registers with wait-state DTACK handshake; CFG_SHADOW_LOCK_EN adds a sticky write lock.
// Latency: dtack rises WAIT_CYCLES+2 edges after select && !FCS_n is first sampled (the edge that samples it counts as the first).
// Backpressure: the master holds FCS_n low until dtack; dtack stays high until FCS_n is sampled high, and FCS_n high in WAIT aborts the cycle.
module cfg_shadow_bank #(
  parameter int NUM_REGS    = 4,
  parameter int ADDR_W      = 4,
  parameter int DATA_W      = 8,
  parameter int WAIT_CYCLES = 1,
  parameter logic [NUM_REGS*DATA_W-1:0] RESET_VALUE = '0
) (
  input  logic                       CLK,
  input  logic                       RESET,
  input  logic                       region_sel,
  input  logic                       READ,
  input  logic                       FCS_n,
  input  logic [ADDR_W-1:0]          ADDR,
  input  logic [DATA_W-1:0]          DIN,
  output logic [DATA_W-1:0]          DOUT,
  output logic                       dtack,
  output logic [NUM_REGS*DATA_W-1:0] reg_q,
  output logic [NUM_REGS-1:0]        reg_wr_stb,
  output logic                       busy
`ifdef CFG_SHADOW_LOCK_EN
  ,
  output logic                       locked
`endif
);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ACCESS, S_HOLD} state_t;

  state_t              state_q, state_d;
  logic [3:0]          cnt_q, cnt_d;
  logic [DATA_W-1:0]   regs [NUM_REGS];
  logic [DATA_W-1:0]   rd_dat;
  logic                lock_set;
  logic                wr_en;

`ifdef CFG_SHADOW_LOCK_EN
  assign lock_set = regs[NUM_REGS-1][DATA_W-1];
  assign locked   = lock_set;
`else
  assign lock_set = 1'b0;
`endif

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (region_sel && !FCS_n) begin
          cnt_d   = 4'(WAIT_CYCLES);
          state_d = (WAIT_CYCLES > 0) ? S_WAIT : S_ACCESS;
        end
      end
      S_WAIT: begin
        // Abort wins over the final wait cycle.
        if (FCS_n) begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q - 4'd1;
          if (cnt_q <= 4'd1) state_d = S_ACCESS;
        end
      end
      S_ACCESS: state_d = S_HOLD;
      S_HOLD:   if (FCS_n) state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // Unmatched (out-of-range) indices fall through to all ones.
  always_comb begin
    rd_dat = '1;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (ADDR == ADDR_W'(i)) rd_dat = regs[i];
    end
  end

  assign wr_en = (state_q == S_ACCESS) && !READ && !lock_set;

  always_ff @(posedge CLK) begin
    if (RESET) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs[i] <= RESET_VALUE[i*DATA_W +: DATA_W];
      end
      DOUT       <= '1;
      reg_wr_stb <= '0;
    end else begin
      reg_wr_stb <= '0;
      if (state_q == S_ACCESS && READ) DOUT <= rd_dat;
      for (int i = 0; i < NUM_REGS; i++) begin
        if (wr_en && ADDR == ADDR_W'(i)) begin
          regs[i]       <= DIN;
          reg_wr_stb[i] <= 1'b1;
        end
      end
    end
  end

  for (genvar g = 0; g < NUM_REGS; g++) begin : g_q
    assign reg_q[g*DATA_W +: DATA_W] = regs[g];
  end

  assign dtack = (state_q == S_HOLD);
  assign busy  = (state_q != S_IDLE);

endmodule

// File: tb/tb_cfg_shadow_bank.sv
// Bench for cfg_shadow_bank: vector table, hand-written corner sequences and random traffic against a register-array model.
module tb_cfg_shadow_bank;

  logic        CLK = 1'b0;
  logic        RESET = 1'b1;
  logic        region_sel = 1'b0;
  logic        READ = 1'b1;
  logic        FCS_n = 1'b1;
  logic        FCS_n3 = 1'b1;
  logic [3:0]  ADDR = '0;
  logic [7:0]  DIN = '0;

  logic [7:0]  DOUT, DOUT3;
  logic        dtack, dtack3, busy, busy3;
  logic [31:0] reg_q, reg_q3;
  logic [3:0]  reg_wr_stb, reg_wr_stb3;
`ifdef CFG_SHADOW_LOCK_EN
  logic        locked, locked3;
`endif

  int tests = 0;
  int fails = 0;

  always #5 CLK = ~CLK;

  cfg_shadow_bank #(.WAIT_CYCLES(1)) dut (
    .CLK(CLK), .RESET(RESET), .region_sel(region_sel), .READ(READ), .FCS_n(FCS_n),
    .ADDR(ADDR), .DIN(DIN), .DOUT(DOUT), .dtack(dtack), .reg_q(reg_q),
    .reg_wr_stb(reg_wr_stb), .busy(busy)
`ifdef CFG_SHADOW_LOCK_EN
    , .locked(locked)
`endif
  );

  cfg_shadow_bank #(.WAIT_CYCLES(3)) dut3 (
    .CLK(CLK), .RESET(RESET), .region_sel(region_sel), .READ(READ), .FCS_n(FCS_n3),
    .ADDR(ADDR), .DIN(DIN), .DOUT(DOUT3), .dtack(dtack3), .reg_q(reg_q3),
    .reg_wr_stb(reg_wr_stb3), .busy(busy3)
`ifdef CFG_SHADOW_LOCK_EN
    , .locked(locked3)
`endif
  );

  typedef struct {
    logic        rd;
    logic [3:0]  a;
    logic [7:0]  d;
    logic [7:0]  e_dout;
    logic [31:0] e_q;
    logic [3:0]  e_stb;
  } vec_t;

  vec_t tbl [11];

  logic [7:0] m [4];
  logic [7:0] m_dout;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge CLK);
    RESET = 1'b1; FCS_n = 1'b1; FCS_n3 = 1'b1; region_sel = 1'b0;
    @(negedge CLK);
    @(negedge CLK);
    RESET = 1'b0;
  endtask

  // Full handshake on the WAIT_CYCLES=1 instance; checks at the dtack cycle and one cycle after release.
  task automatic bus(input logic rd, input logic [3:0] a, input logic [7:0] d,
                     input logic [7:0] e_dout, input logic [31:0] e_q,
                     input logic [3:0] e_stb, input string nm);
    int   lat;
    logic early;
    @(negedge CLK);
    READ = rd; ADDR = a; DIN = d; region_sel = 1'b1; FCS_n = 1'b0;
    lat = 0; early = 1'b0;
    do begin
      @(negedge CLK);
      lat++;
      region_sel = 1'b0;
      if (!dtack && reg_wr_stb != 4'b0) early = 1'b1;
    end while (!dtack && lat < 20);
    chk({nm, " latency"}, 64'(lat), 64'd3);
    chk({nm, " early_stb"}, 64'(early), 64'd0);
    chk({nm, " dout"}, 64'(DOUT), 64'(e_dout));
    chk({nm, " reg_q"}, 64'(reg_q), 64'(e_q));
    chk({nm, " stb"}, 64'(reg_wr_stb), 64'(e_stb));
    FCS_n = 1'b1;
    @(negedge CLK);
    chk({nm, " release"}, 64'({dtack, busy, reg_wr_stb}), 64'd0);
  endtask

  // Reference model: expectations from the register-file rules, then drive the handshake.
  task automatic model_op(input logic rd, input logic [3:0] a, input logic [7:0] d, input string nm);
    logic       wr_ok;
    logic [3:0] stb;
    stb = 4'b0;
    if (rd) begin
      m_dout = (a < 4) ? m[a[1:0]] : 8'hFF;
    end else begin
      wr_ok = (a < 4);
`ifdef CFG_SHADOW_LOCK_EN
      if (m[3][7]) wr_ok = 1'b0;
`endif
      if (wr_ok) begin
        m[a[1:0]] = d;
        stb = 4'b0001 << a[1:0];
      end
    end
    bus(rd, a, d, m_dout, {m[3], m[2], m[1], m[0]}, stb, nm);
  endtask

  initial begin
    int   lat;
    logic seen;

    tbl[0]  = '{1'b0, 4'd0,  8'h01, 8'hFF, 32'h0000_0001, 4'b0001};
    tbl[1]  = '{1'b1, 4'd0,  8'h00, 8'h01, 32'h0000_0001, 4'b0000};
    tbl[2]  = '{1'b1, 4'd9,  8'h00, 8'hFF, 32'h0000_0001, 4'b0000};
    tbl[3]  = '{1'b0, 4'd2,  8'h5A, 8'hFF, 32'h005A_0001, 4'b0100};
    tbl[4]  = '{1'b0, 4'd7,  8'h33, 8'hFF, 32'h005A_0001, 4'b0000};
    tbl[5]  = '{1'b1, 4'd2,  8'h00, 8'h5A, 32'h005A_0001, 4'b0000};
    tbl[6]  = '{1'b0, 4'd1,  8'hC3, 8'h5A, 32'h005A_C301, 4'b0010};
    tbl[7]  = '{1'b1, 4'd1,  8'h00, 8'hC3, 32'h005A_C301, 4'b0000};
    tbl[8]  = '{1'b0, 4'd3,  8'h7F, 8'hC3, 32'h7F5A_C301, 4'b1000};
    tbl[9]  = '{1'b1, 4'd3,  8'h00, 8'h7F, 32'h7F5A_C301, 4'b0000};
    tbl[10] = '{1'b1, 4'd15, 8'h00, 8'hFF, 32'h7F5A_C301, 4'b0000};

    do_reset();
    @(negedge CLK);
    chk("reset reg_q", 64'(reg_q), 64'd0);
    chk("reset dout", 64'(DOUT), 64'hFF);
    chk("reset dtack/busy/stb", 64'({dtack, busy, reg_wr_stb}), 64'd0);
    chk("reset dut3", 64'({DOUT3, reg_q3, dtack3, busy3, reg_wr_stb3}), {24'd0, 8'hFF, 32'd0, 6'd0});

    // WAIT_CYCLES=3 instance: normal write latency, then abort in the second wait cycle.
    @(negedge CLK);
    READ = 1'b0; ADDR = 4'd2; DIN = 8'h3C; region_sel = 1'b1; FCS_n3 = 1'b0;
    lat = 0;
    do begin
      @(negedge CLK);
      lat++;
    end while (!dtack3 && lat < 20);
    chk("w3 latency", 64'(lat), 64'd5);
    chk("w3 reg_q", 64'(reg_q3), 64'h003C_0000);
    chk("w3 stb", 64'(reg_wr_stb3), 64'b0100);
    FCS_n3 = 1'b1; region_sel = 1'b0;
    @(negedge CLK);
    chk("w3 release", 64'({dtack3, busy3}), 64'd0);

    @(negedge CLK);
    READ = 1'b0; ADDR = 4'd1; DIN = 8'hAA; region_sel = 1'b1; FCS_n3 = 1'b0;
    @(negedge CLK);
    chk("abort busy in wait", 64'(busy3), 64'd1);
    @(negedge CLK);
    FCS_n3 = 1'b1; region_sel = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge CLK);
      if (dtack3 || reg_wr_stb3 != 4'b0) seen = 1'b1;
    end
    chk("abort no dtack/stb", 64'(seen), 64'd0);
    chk("abort reg_q", 64'(reg_q3), 64'h003C_0000);
    chk("abort busy", 64'(busy3), 64'd0);

    for (int i = 0; i < 11; i++) begin
      bus(tbl[i].rd, tbl[i].a, tbl[i].d, tbl[i].e_dout, tbl[i].e_q, tbl[i].e_stb,
          $sformatf("vec%0d", i));
    end

    // Reset while the write is sitting in HOLD.
    @(negedge CLK);
    READ = 1'b0; ADDR = 4'd0; DIN = 8'h11; region_sel = 1'b1; FCS_n = 1'b0;
    lat = 0;
    do begin
      @(negedge CLK);
      lat++;
    end while (!dtack && lat < 20);
    chk("hold reached", 64'(dtack), 64'd1);
    RESET = 1'b1; FCS_n = 1'b1; region_sel = 1'b0;
    @(negedge CLK);
    chk("hold reset dtack/busy/stb", 64'({dtack, busy, reg_wr_stb}), 64'd0);
    chk("hold reset reg_q", 64'(reg_q), 64'd0);
    chk("hold reset dout", 64'(DOUT), 64'hFF);
    RESET = 1'b0;
    bus(1'b1, 4'd0, 8'h00, 8'h00, 32'h0, 4'b0, "post-reset read");

    do_reset();
    for (int i = 0; i < 4; i++) m[i] = 8'h00;
    m_dout = 8'hFF;
    for (int i = 0; i < 40; i++) begin
      model_op(1'($urandom_range(0, 1)), 4'($urandom_range(0, 5)), 8'($urandom),
               $sformatf("rand%0d", i));
    end

    do_reset();
`ifdef CFG_SHADOW_LOCK_EN
    bus(1'b0, 4'd3, 8'h80, 8'hFF, 32'h8000_0000, 4'b1000, "lock set");
    chk("locked", 64'(locked), 64'd1);
    bus(1'b0, 4'd0, 8'h55, 8'hFF, 32'h8000_0000, 4'b0000, "locked write");
    bus(1'b1, 4'd0, 8'h00, 8'h00, 32'h8000_0000, 4'b0000, "locked read");
`else
    bus(1'b0, 4'd3, 8'h80, 8'hFF, 32'h8000_0000, 4'b1000, "bit7 write");
    bus(1'b0, 4'd0, 8'h55, 8'hFF, 32'h8000_0055, 4'b0001, "write after bit7");
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
